srl_fifo: RTL
=============

# srl_fifo

Synchronous FIFO whose storage is a per-bit shift-register array (SRL-inferable) that is written by shifting in at tap 0 and read from an addressable tap. It is the read-side counterpart to the fixed-delay shift-register bus: instead of always taking the last tap, it selects the oldest valid entry. It sits between producer and consumer pipeline stages, absorbing rate mismatch with a first-word-fall-through valid/ready-style interface.

## Interface
- C_DATA_WIDTH, 32, width of each entry
- C_DEPTH, 16, SRL entries (≥2; any integer, not restricted to powers of 2)
- C_AFULL_THRESH, C_DEPTH-2, almost_full asserts when count ≥ this value
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  push request
- wr_data  input  C_DATA_WIDTH  push data
- full  output  1  no space; push ignored unless paired with an accepted pop
- almost_full  output  1  count ≥ C_AFULL_THRESH
- rd_en  input  1  pop request (acknowledge of current rd_data)
- rd_data  output  C_DATA_WIDTH  oldest entry (first-word fall-through)
- empty  output  1  no entry presented on rd_data
- count  output  $clog2(CAP+1)  occupancy; CAP = C_DEPTH (C_DEPTH+1 with SRL_FIFO_OREG_EN)

## Operation
- Accepted push: wr_en & (~full | pop_accepted). All SRL entries shift one position (entry k → k+1), wr_data enters entry 0. Storage is never reset and has no reset term (keeps SRL inference).
- Accepted pop: rd_en & ~empty. No data movement; only occupancy decreases.
- Read tap pointer ptr = SRL occupancy − 1; rd_data = srl[ptr].
- Occupancy update: push-only +1, pop-only −1, both or neither unchanged.
- Push + pop while full: both accepted, count stays CAP, rd_data advances to next-oldest entry.
- Push + pop while empty: push accepted, pop ignored.
- Push while full without pop: dropped, no state change. Pop while empty: ignored.
- Flags registered, derived from next occupancy: empty = (count==0), full = (count==CAP), almost_full = (count ≥ C_AFULL_THRESH).
- Reset (any time, including mid-transfer): count=0, empty=1, full=0, almost_full=0 asynchronously; stored data is lost logically. rd_data is don't-care while empty=1.

## Timing
- Push at edge t into empty FIFO: empty=0 and rd_data=pushed word after edge t (visible in cycle t+1).
- Pop at edge t: rd_data shows the next entry in cycle t+1; empty rises after edge t if that was the last entry.
- full rises after the edge accepting the CAP-th word; falls after the edge of the first pop-only.
- Throughput: one push and one pop per cycle sustained, including at full and near-empty.
- rd_data path (no macro): combinational mux from SRL tap; flags and count registered.

## Configuration
- SRL_FIFO_OREG_EN defined: adds an output register stage ahead of rd_data. The head entry is moved from the SRL into the register whenever the register is empty or is being popped and the SRL is non-empty; a push into a fully empty FIFO goes directly to the register. CAP = C_DEPTH+1, and count covers SRL plus register. Push-to-empty-deassert latency is still 1 cycle through the bypass. rd_data is a flop output, reset to 0.
- Undefined: no output register; CAP = C_DEPTH; rd_data is the combinational tap mux.

## Test plan
- Reset then push 0xA0..0xA3 on consecutive cycles, then pop 4 → rd_data 0xA0,0xA1,0xA2,0xA3; empty=1 afterward and count=0.
- Fill to CAP with 0x100+i and push 0xDEAD while full → full=1, count=CAP, 0xDEAD never appears on read.
- At full, do 20 cycles of simultaneous push/pop with incrementing data → count stays CAP, output is strictly in order, and there are no drops.
- Empty FIFO with rd_en=1 and wr_en=1 in the same cycle, data 0x55 → next cycle empty=0, count=1, rd_data=0x55.
- C_AFULL_THRESH=14, C_DEPTH=16: push 13 → almost_full=0; push 14th → almost_full=1 after that edge.
- Assert rst_n low asynchronously mid-burst at count=7 → empty=1, count=0, full=0 immediately, without waiting for a clock edge. After release, push 0x77 → rd_data=0x77.

Source files
------------

// File: rtl/srl_fifo.sv
// rtl/srl_fifo.sv - first-word-fall-through FIFO on an SRL-inferable shift array read at an addressable tap
// Optional output register stage: define SRL_FIFO_OREG_EN.
module srl_fifo #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_DEPTH        = 16,
    parameter int C_AFULL_THRESH = C_DEPTH - 2,
`ifdef SRL_FIFO_OREG_EN
    localparam int CAP           = C_DEPTH + 1,
`else
    localparam int CAP           = C_DEPTH,
`endif
    localparam int CNT_W         = $clog2(CAP + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic                    empty,
    output logic [CNT_W-1:0]        count
);

    localparam int SW = $clog2(C_DEPTH + 1);
    localparam int AW = $clog2(C_DEPTH);

    logic [C_DATA_WIDTH-1:0] srl [C_DEPTH];
    logic [SW-1:0]           srl_cnt;
    logic [SW-1:0]           srl_cnt_nxt;
    logic [CNT_W-1:0]        count_nxt;
    logic [AW-1:0]           ptr;
    logic [C_DATA_WIDTH-1:0] head;
    logic                    pop_acc;
    logic                    push_acc;
    logic                    srl_push;
    logic                    srl_pop;

    assign pop_acc  = rd_en & ~empty;
    assign push_acc = wr_en & (~full | pop_acc);

    // Oldest SRL entry sits at tap occupancy-1; tap 0 is a safe value when empty.
    always_comb begin
        ptr = '0;
        if (srl_cnt != '0) begin
            ptr = AW'(srl_cnt - SW'(1));
        end
    end
    assign head = srl[ptr];

    always_ff @(posedge clk) begin
        if (srl_push) begin
            srl[0] <= wr_data;
            for (int k = 1; k < C_DEPTH; k++) begin
                srl[k] <= srl[k-1];
            end
        end
    end

    always_comb begin
        srl_cnt_nxt = srl_cnt;
        if (srl_push && !srl_pop) begin
            srl_cnt_nxt = srl_cnt + SW'(1);
        end else if (!srl_push && srl_pop) begin
            srl_cnt_nxt = srl_cnt - SW'(1);
        end
    end

`ifdef SRL_FIFO_OREG_EN
    logic                    oreg_valid;
    logic                    oreg_valid_nxt;
    logic [C_DATA_WIDTH-1:0] oreg;
    logic                    oreg_free;
    logic                    oreg_bypass;

    // The register is refilled whenever it will be vacant after this edge;
    // a push into a completely empty FIFO skips the SRL entirely.
    assign oreg_free      = ~oreg_valid | pop_acc;
    assign srl_pop        = oreg_free & (srl_cnt != '0);
    assign oreg_bypass    = oreg_free & (srl_cnt == '0) & push_acc;
    assign srl_push       = push_acc & ~oreg_bypass;
    assign oreg_valid_nxt = srl_pop | oreg_bypass | (oreg_valid & ~pop_acc);
    assign count_nxt      = CNT_W'(srl_cnt_nxt) + CNT_W'(oreg_valid_nxt);
    assign rd_data        = oreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_valid <= 1'b0;
            oreg       <= '0;
        end else begin
            oreg_valid <= oreg_valid_nxt;
            if (srl_pop) begin
                oreg <= head;
            end else if (oreg_bypass) begin
                oreg <= wr_data;
            end
        end
    end
`else
    assign srl_pop   = pop_acc;
    assign srl_push  = push_acc;
    assign count_nxt = CNT_W'(srl_cnt_nxt);
    assign rd_data   = head;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srl_cnt     <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            srl_cnt     <= srl_cnt_nxt;
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CNT_W'(CAP));
            almost_full <= (count_nxt >= CNT_W'(C_AFULL_THRESH));
        end
    end

endmodule
